// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Brief    : Data-memory request/response bundle between the LSU and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding load/store unit with alignment check,
//            byte lanes, ack timeout and register-file writeback.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic        is_load,
    input  wire logic        is_byte,
    input  wire logic [31:0] base,
    input  wire logic [11:0] offset,
    input  wire logic        up,
    input  wire logic [31:0] store_data,
    input  wire logic [3:0]  dest_reg,
    output logic             ready,
    load_store_unit_if.master mem,
    output logic             wb_en,
    output logic [3:0]       wb_reg,
    output logic [31:0]      wb_data,
    output logic             fault
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACCESS    = 2'd1,
        S_WRITEBACK = 2'd2
    } state_t;

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_count;
    logic        r_is_load;
    logic        r_is_byte;
    logic        r_fault;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [3:0]  r_wb_reg;
    logic [31:0] r_wb_data;

    logic [31:0] w_addr;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_expired;
    logic [7:0]  w_lane;
    logic [31:0] w_load_data;

    assign w_addr       = up ? (base + {20'd0, offset}) : (base - {20'd0, offset});
    assign w_misaligned = !is_byte && (w_addr[1:0] != 2'b00);
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_expired    = (r_count == c_timeout_last);

    // Little-endian lane select for byte loads, zero-extended.
    always_comb begin
        w_lane = mem.mem_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_lane = mem.mem_rdata[7:0];
            2'd1:    w_lane = mem.mem_rdata[15:8];
            2'd2:    w_lane = mem.mem_rdata[23:16];
            default: w_lane = mem.mem_rdata[31:24];
        endcase
        w_load_data = r_is_byte ? {24'd0, w_lane} : mem.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_misaligned) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // An ack on the final counted cycle still wins over the timeout.
                if (mem.mem_ack) begin
                    w_next_state = r_is_load ? S_WRITEBACK : S_IDLE;
                end else if (w_expired) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WRITEBACK: w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 8'd0;
            r_is_load <= 1'b0;
            r_is_byte <= 1'b0;
            r_fault   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_wb_reg  <= 4'd0;
            r_wb_data <= 32'd0;
        end else begin
            r_fault <= 1'b0;
            if (w_accept) begin
                r_fault <= w_misaligned;
                if (!w_misaligned) begin
                    r_count   <= 8'd0;
                    r_is_load <= is_load;
                    r_is_byte <= is_byte;
                    r_we      <= !is_load;
                    r_addr    <= w_addr;
                    r_wb_reg  <= dest_reg;
                    r_be      <= is_byte ? (4'b0001 << w_addr[1:0]) : 4'b1111;
                    r_wdata   <= is_byte ? {4{store_data[7:0]}} : store_data;
                end
            end
            if (r_state == S_ACCESS) begin
                if (mem.mem_ack) begin
                    r_wb_data <= w_load_data;
                end else if (w_expired) begin
                    r_fault <= 1'b1;
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    assign ready         = (r_state == S_IDLE);
    assign mem.mem_req   = (r_state == S_ACCESS);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_be    = r_be;
    // The PC (r15) is never written through the load path.
    assign wb_en         = (r_state == S_WRITEBACK) && (r_wb_reg != 4'd15);
    assign wb_reg        = r_wb_reg;
    assign wb_data       = r_wb_data;
    assign fault         = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        is_byte;
    logic [31:0] base;
    logic [11:0] offset;
    logic        up;
    logic [31:0] store_data;
    logic [3:0]  dest_reg;
    logic        ready;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_load    (is_load),
        .is_byte    (is_byte),
        .base       (base),
        .offset     (offset),
        .up         (up),
        .store_data (store_data),
        .dest_reg   (dest_reg),
        .ready      (ready),
        .mem        (mem_bus.master),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic byt, input logic [31:0] b,
                         input logic [11:0] off, input logic u, input logic [31:0] sd,
                         input logic [3:0] dst);
        is_load = ld; is_byte = byt; base = b; offset = off; up = u;
        store_data = sd; dest_reg = dst; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_byte = 1'b0;
        base = 32'd0; offset = 12'd0; up = 1'b1; store_data = 32'd0; dest_reg = 4'd0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'd0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_req", mem_bus.mem_req, 0);
        chk("rst_we", mem_bus.mem_we, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", mem_bus.mem_addr, 0);
        chk("rst_be", mem_bus.mem_be, 0);
        chk("rst_wb_data", wb_data, 0);
        rst_n = 1'b1;
        step();

        // Word load 0x100+4, ack on second ACCESS cycle
        issue(1'b1, 1'b0, 32'h100, 12'd4, 1'b1, 32'h0, 4'd3);
        chk("wl_req", mem_bus.mem_req, 1);
        chk("wl_ready", ready, 0);
        chk("wl_addr", mem_bus.mem_addr, 32'h104);
        chk("wl_be", mem_bus.mem_be, 4'b1111);
        chk("wl_we", mem_bus.mem_we, 0);
        step();
        chk("wl_req2", mem_bus.mem_req, 1);
        chk("wl_addr2", mem_bus.mem_addr, 32'h104);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEADBEEF;
        step();
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h0;
        chk("wl_req_drop", mem_bus.mem_req, 0);
        chk("wl_wb_en", wb_en, 1);
        chk("wl_wb_reg", wb_reg, 3);
        chk("wl_wb_data", wb_data, 32'hDEADBEEF);
        step();
        chk("wl_wb_en_off", wb_en, 0);
        chk("wl_ready_back", ready, 1);

        // Byte store to 0x203
        issue(1'b0, 1'b1, 32'h203, 12'd0, 1'b1, 32'h000000A5, 4'd1);
        chk("bs_we", mem_bus.mem_we, 1);
        chk("bs_be", mem_bus.mem_be, 4'b1000);
        chk("bs_wdata", mem_bus.mem_wdata, 32'hA5A5A5A5);
        chk("bs_wb_en", wb_en, 0);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("bs_ready", ready, 1);
        chk("bs_req", mem_bus.mem_req, 0);
        chk("bs_wb_en2", wb_en, 0);

        // Byte load at 0x12 (0x10+2)
        issue(1'b1, 1'b1, 32'h10, 12'd2, 1'b1, 32'h0, 4'd5);
        chk("bl_addr", mem_bus.mem_addr, 32'h12);
        chk("bl_be", mem_bus.mem_be, 4'b0100);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h11223344;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("bl_wb_en", wb_en, 1);
        chk("bl_wb_reg", wb_reg, 5);
        chk("bl_wb_data", wb_data, 32'h00000022);
        step();

        // Misaligned word load: 0 - 1 = 0xFFFFFFFF
        issue(1'b1, 1'b0, 32'h0, 12'd1, 1'b0, 32'h0, 4'd2);
        chk("mis_fault", fault, 1);
        chk("mis_req", mem_bus.mem_req, 0);
        chk("mis_ready", ready, 1);
        step();
        chk("mis_fault_end", fault, 0);
        chk("mis_req2", mem_bus.mem_req, 0);
        chk("mis_wb_en", wb_en, 0);

        // Word store downwards, no ack: timeout after 4 cycles
        issue(1'b0, 1'b0, 32'h48, 12'd8, 1'b0, 32'h12345678, 4'd1);
        chk("to_addr", mem_bus.mem_addr, 32'h40);
        chk("to_wdata", mem_bus.mem_wdata, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", mem_bus.mem_req, 1);
            chk("to_no_fault", fault, 0);
            step();
        end
        chk("to_req_drop", mem_bus.mem_req, 0);
        chk("to_fault", fault, 1);
        chk("to_ready", ready, 1);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("to_late_fault", fault, 0);
        chk("to_late_req", mem_bus.mem_req, 0);
        chk("to_late_wb", wb_en, 0);
        chk("to_late_ready", ready, 1);

        // Ack on the same edge the count expires: success, no fault
        issue(1'b1, 1'b0, 32'h80, 12'd0, 1'b1, 32'h0, 4'd7);
        step(); step(); step();
        chk("edge_req", mem_bus.mem_req, 1);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("edge_fault", fault, 0);
        chk("edge_wb_en", wb_en, 1);
        chk("edge_wb_data", wb_data, 32'hCAFEF00D);
        step();

        // Load into r15: WRITEBACK without wb_en
        issue(1'b1, 1'b0, 32'h84, 12'd0, 1'b1, 32'h0, 4'd15);
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h5555AAAA;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("pc_wb_en", wb_en, 0);
        chk("pc_fault", fault, 0);
        chk("pc_ready_wb", ready, 0);
        step();
        chk("pc_ready", ready, 1);

        // Reset during ACCESS, then a stray ack
        issue(1'b1, 1'b0, 32'h90, 12'd0, 1'b1, 32'h0, 4'd4);
        chk("ra_req", mem_bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_async_ready", ready, 1);
        chk("ra_async_req", mem_bus.mem_req, 0);
        chk("ra_async_addr", mem_bus.mem_addr, 0);
        #2 rst_n = 1'b1;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hFFFFFFFF;
        step();
        mem_bus.mem_ack = 1'b0;
        chk("ra_ready", ready, 1);
        chk("ra_req2", mem_bus.mem_req, 0);
        chk("ra_wb_en", wb_en, 0);
        step();
        chk("ra_wb_en2", wb_en, 0);
        chk("ra_wb_data", wb_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of ACCESS cycles to wait for mem_ack before aborting (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports start  input  1  (issue strobe), is_load  input  1  (1=load, 0=store) and is_byte  input  1  (1=byte, 0=word).
REQ-005 SHALL have ports base  input  32  (register-file read port 1 value), offset  input  12  (unsigned immediate) and up  input  1  (1=add offset, 0=subtract offset).
REQ-006 SHALL have ports store_data  input  32  (register-file read port 2 value) and dest_reg  input  4  (load destination register).
REQ-007 SHALL have port ready  output  1  (unit idle and able to accept start).
REQ-008 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32 and mem_be  output  4, forming the data-memory request.
REQ-009 SHALL have ports mem_ack  input  1  (memory completion) and mem_rdata  input  32  (read data, valid with mem_ack).
REQ-010 SHALL have ports wb_en  output  1, wb_reg  output  4 and wb_data  output  32, driving the register-file write port.
REQ-011 SHALL have port fault  output  1  (one-cycle pulse on misalignment or timeout).

Function
REQ-012 SHALL implement the FSM states IDLE, ACCESS and WRITEBACK, with ready=1 only in IDLE.
REQ-013 SHALL capture all issue inputs on a clock edge where start=1 in IDLE; start in any other state SHALL be ignored.
REQ-014 SHALL compute the address, modulo 2^32, as base + zero-extended offset when up=1, or base - offset when up=0.
REQ-015 SHALL, for a word access with address[1:0] != 0, pulse fault the next cycle, issue no mem_req, perform no writeback and remain in IDLE.
REQ-016 SHALL otherwise enter ACCESS the next cycle, with mem_req=1 and mem_addr, mem_we (= !is_load), mem_be and mem_wdata all held stable until the edge on which mem_ack=1 is sampled.
REQ-017 SHALL drive word accesses with mem_be=4'b1111 and mem_wdata=store_data.
REQ-018 SHALL drive byte accesses with mem_be = 1 << addr[1:0] and mem_wdata = store_data[7:0] replicated to all four lanes.
REQ-019 SHALL, on mem_ack in ACCESS, drop mem_req in the next cycle and then go to WRITEBACK for a load or to IDLE for a store.
REQ-020 SHALL, in WRITEBACK (exactly one cycle), drive wb_en=1, wb_reg=dest_reg and wb_data = mem_rdata captured at ack, then return to IDLE.
REQ-021 SHALL form byte-load data from lane addr[1:0] of mem_rdata, little-endian and zero-extended to 32 bits.
REQ-022 SHALL keep wb_en=0 in WRITEBACK when dest_reg=15 (the PC is not written through this path), with no fault raised.
REQ-023 SHALL count cycles in ACCESS and, when the count reaches TIMEOUT without mem_ack, drop mem_req, pulse fault, perform no writeback and return to IDLE.
REQ-024 SHALL ignore mem_ack and mem_rdata when not in ACCESS.
REQ-025 SHALL treat a mem_ack arriving on the same edge the count reaches TIMEOUT as a successful ack, with no fault.
REQ-026 SHALL give a load a latency, from the start edge, of 1 + N cycles to the ack edge plus 1 WRITEBACK cycle, where N≥1 is the number of ACCESS cycles; ready SHALL reassert the cycle after WRITEBACK.
REQ-027 SHALL hold wb_en, fault and mem_req at 0 outside the states and pulses defined above.

Reset
REQ-028 SHALL, on rst_n=0, immediately and asynchronously enter IDLE with ready=1 and with mem_req, mem_we, wb_en and fault at 0.
REQ-029 SHALL, on rst_n=0, clear mem_addr, mem_wdata, wb_data, mem_be, wb_reg and the timeout counter to 0.
REQ-030 SHALL abandon any in-flight access when reset is asserted mid-ACCESS, with no writeback after release.
REQ-031 SHALL ignore a mem_ack arriving after reset release while the unit is in IDLE.

Verification
REQ-032 SHALL cover: word load, base=0x100, offset=4, up=1, dest=3, ack after 2 cycles with rdata=0xDEADBEEF -> mem_addr=0x104, mem_be=1111, then one wb_en pulse with wb_reg=3, wb_data=0xDEADBEEF.
REQ-033 SHALL cover: byte store, base=0x203, offset=0, store_data=0x000000A5 -> mem_we=1, mem_be=1000, mem_wdata=0xA5A5A5A5, ready again the cycle after ack, wb_en never asserted.
REQ-034 SHALL cover: byte load, addr=0x12, rdata=0x11223344 -> wb_data=0x00000022.
REQ-035 SHALL cover: word load, base=0x0, offset=1, up=0 -> mem_addr would be 0xFFFFFFFF (misaligned) -> fault pulse the next cycle, mem_req never asserted.
REQ-036 SHALL cover: TIMEOUT=4, mem_ack held at 0 -> mem_req high for exactly 4 cycles, then fault pulse and ready=1; a late ack is ignored.
REQ-037 SHALL cover: rst_n pulsed low during ACCESS, followed by mem_ack -> ready=1, and wb_en and mem_req remain 0.
